// File: rtl/and4_stream.sv
// Registered streaming bitwise-AND with valid/ready handshakes and a one-entry
// skid buffer, so in_ready is a function of local state only, never of out_ready.

module and4_lane (
  input  logic a,
  input  logic b,
  output logic y,
  output logic eq
);
  assign y  = a & b;
  // y bit matches b bit unless b is set and a is clear
  assign eq = a | ~b;
endmodule

module and4_stream #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             y_eq_b
);

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             y_zero;
    logic             y_eq_b;
  } res_t;

  logic [WIDTH-1:0] and_bits;
  logic [WIDTH-1:0] eq_bits;
  res_t             new_res;
  res_t             out_res;
  res_t             skid_res;
  logic             out_full;
  logic             skid_full;
  logic             accept;
  logic             xfer;
  logic             out_load;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    and4_lane u_lane (
      .a  (a[i]),
      .b  (b[i]),
      .y  (and_bits[i]),
      .eq (eq_bits[i])
    );
  end

  assign new_res.y      = and_bits;
  assign new_res.y_zero = ~|and_bits;
  assign new_res.y_eq_b = &eq_bits;

  // Reset gates in_ready so nothing is taken during the reset cycle itself.
  assign in_ready = ~skid_full & ~rst;
  assign accept   = in_valid & in_ready;
  assign xfer     = out_full & out_ready;
  assign out_load = ~out_full | xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_full  <= 1'b0;
      skid_full <= 1'b0;
      out_res   <= '0;
      skid_res  <= '0;
    end else if (out_load) begin
      // Skid is older than anything arriving now; in_ready is low while it is full.
      if (skid_full) begin
        out_res   <= skid_res;
        out_full  <= 1'b1;
        skid_full <= 1'b0;
      end else if (accept) begin
        out_res  <= new_res;
        out_full <= 1'b1;
      end else begin
        out_full <= 1'b0;
      end
    end else if (accept) begin
      skid_res  <= new_res;
      skid_full <= 1'b1;
    end
  end

  assign out_valid = out_full;
  assign y         = out_res.y;
  assign y_zero    = out_res.y_zero;
  assign y_eq_b    = out_res.y_eq_b;

endmodule

// File: tb/tb_and4_stream.sv
// Directed bench for and4_stream: vector table for the AND/flag function plus
// hand sequences for streaming, backpressure, mid-stream reset, idle and WIDTH=8.

module tb_and4_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] y;
  logic       y_zero;
  logic       y_eq_b;

  logic       in_valid8;
  logic       in_ready8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       out_valid8;
  logic [7:0] y8;
  logic       y_zero8;
  logic       y_eq_b8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  and4_stream #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_zero(y_zero), .y_eq_b(y_eq_b)
  );

  and4_stream #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(1'b1),
    .y(y8), .y_zero(y_zero8), .y_eq_b(y_eq_b8)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
    logic       z;
    logic       e;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic v, input logic [3:0] ey,
                           input logic ez, input logic ee);
    check({name, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    check({name, ".y"}, {28'd0, y}, {28'd0, ey});
    check({name, ".zero"}, {31'd0, y_zero}, {31'd0, ez});
    check({name, ".eqb"}, {31'd0, y_eq_b}, {31'd0, ee});
  endtask

  initial begin
    vecs[0] = '{a: 4'b0000, b: 4'b0000, y: 4'b0000, z: 1'b1, e: 1'b1};
    vecs[1] = '{a: 4'b1010, b: 4'b0101, y: 4'b0000, z: 1'b1, e: 1'b0};
    vecs[2] = '{a: 4'b1111, b: 4'b1010, y: 4'b1010, z: 1'b0, e: 1'b1};
    vecs[3] = '{a: 4'b1100, b: 4'b0110, y: 4'b0100, z: 1'b0, e: 1'b0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0;

    // Reset state
    @(negedge clk);
    check("rst.in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check_out("rst", 1'b0, 4'b0000, 1'b0, 1'b0);
    check("rst.in_ready2", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst.in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("post_rst.valid", {31'd0, out_valid}, 32'd0);

    // Single transactions, one-cycle latency
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b;
      @(negedge clk);
      in_valid = 1'b0; a = 4'hx; b = 4'hx;
      check_out($sformatf("basic%0d", i), 1'b1, vecs[i].y, vecs[i].z, vecs[i].e);
      @(negedge clk);
      check($sformatf("basic%0d.drain", i), {31'd0, out_valid}, 32'd0);
    end

    // Back-to-back streaming
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b;
      @(negedge clk);
      check_out($sformatf("stream%0d", i), 1'b1, vecs[i].y, vecs[i].z, vecs[i].e);
      check($sformatf("stream%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream.end", {31'd0, out_valid}, 32'd0);

    // Backpressure fills the skid
    out_ready = 1'b0;
    in_valid = 1'b1; a = 4'b1111; b = 4'b1010;
    @(negedge clk);
    check_out("bp.first", 1'b1, 4'b1010, 1'b0, 1'b1);
    check("bp.in_ready1", {31'd0, in_ready}, 32'd1);
    a = 4'b1100; b = 4'b0110;
    @(negedge clk);
    check_out("bp.hold", 1'b1, 4'b1010, 1'b0, 1'b1);
    check("bp.in_ready0", {31'd0, in_ready}, 32'd0);
    a = 4'b0000; b = 4'b0000;   // must not be taken while in_ready is low
    @(negedge clk);
    check_out("bp.hold2", 1'b1, 4'b1010, 1'b0, 1'b1);
    check("bp.in_ready0b", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_out("bp.skid_out", 1'b1, 4'b0100, 1'b0, 1'b0);
    check("bp.in_ready_back", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("bp.drain", {31'd0, out_valid}, 32'd0);

    // Reset with output and skid both full
    out_ready = 1'b0;
    in_valid = 1'b1; a = 4'b1111; b = 4'b1111;
    @(negedge clk);
    a = 4'b0111; b = 4'b0011;
    @(negedge clk);
    check("mr.full", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mr.in_ready_rst", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check_out("mr.rst", 1'b0, 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("mr.in_ready_after", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("mr.no_old%0d", i), {31'd0, out_valid}, 32'd0);
    end

    // Idle with garbage on a/b
    for (int i = 0; i < 8; i++) begin
      a = 4'($urandom); b = 4'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      check($sformatf("idle%0d.valid", i), {31'd0, out_valid}, 32'd0);
      check($sformatf("idle%0d.y", i), {28'd0, y}, 32'd0);
    end

    // WIDTH=8 instance
    in_valid8 = 1'b1; a8 = 8'hF0; b8 = 8'h3C;
    @(negedge clk);
    in_valid8 = 1'b0;
    check("w8.valid", {31'd0, out_valid8}, 32'd1);
    check("w8.y", {24'd0, y8}, 32'h30);
    check("w8.zero", {31'd0, y_zero8}, 32'd0);
    check("w8.eqb", {31'd0, y_eq_b8}, 32'd0);
    check("w8.in_ready", {31'd0, in_ready8}, 32'd1);
    @(negedge clk);
    check("w8.drain", {31'd0, out_valid8}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
